// File: rtl/pec_row_sched_pkg.sv
// Shared definitions for the PEC row/block/frame sequencer: default sizes and FSM states.
package pec_row_sched_pkg;

  localparam int unsigned ACT_CNT_W_DEF = 8;
  localparam int unsigned ROW_CNT_W_DEF = 6;
  localparam int unsigned BLK_CNT_W_DEF = 8;
  localparam int unsigned DRAIN_CYC_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STAROW,
    ST_FEED,
    ST_DRAIN,
    ST_FNHROW,
    ST_FNHBLK,
    ST_FNHFRM
  } state_e;

endpackage

// File: rtl/pec_row_sched_cnt.sv
// Loadable terminal-count counter: load latches the count (0 treated as 1), last_o flags the final value.
module pec_row_sched_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] num_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic         last_o
);

  logic [W-1:0] term_q;
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      // Terminal value is stored as N-1 so a zero config collapses to a single step.
      term_q <= (num_i == '0) ? '0 : num_i - W'(1);
      cnt_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= last_o ? '0 : cnt_q + W'(1);
    end
  end

  assign last_o = (cnt_q == term_q);

endmodule

// File: rtl/pec_row_sched.sv
// PEC chain sequencer: rows -> blocks -> frame, with Rdy/Get activation metering.
// Optional perf counters (StallCyc, FrmCyc) are built when PEC_ROW_SCHED_PERF_EN is defined.
module pec_row_sched
  import pec_row_sched_pkg::*;
#(
  parameter int unsigned ACT_CNT_W = ACT_CNT_W_DEF,
  parameter int unsigned ROW_CNT_W = ROW_CNT_W_DEF,
  parameter int unsigned BLK_CNT_W = BLK_CNT_W_DEF,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 TOPPEB_Start,
  input  logic [ACT_CNT_W-1:0] TOPPEB_NumAct,
  input  logic [ROW_CNT_W-1:0] TOPPEB_NumRow,
  input  logic [BLK_CNT_W-1:0] TOPPEB_NumBlk,
  input  logic                 ACTPEB_Vld,
  output logic                 PEBACT_Pop,
  output logic                 PEBPEC_RdyAct,
  input  logic                 PECPEB_GetAct,
  output logic                 PEBPEC_StaRow,
  output logic                 PEBPEC_FnhRow,
  output logic                 PEBPEC_FnhBlk,
  output logic                 PEBPEC_FnhFrm,
  output logic                 PEBTOP_Busy,
  output logic                 PEBTOP_Err
`ifdef PEC_ROW_SCHED_PERF_EN
  ,
  output logic [31:0]          PEBTOP_StallCyc,
  output logic [31:0]          PEBTOP_FrmCyc
`endif
);

  localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e           state_q;
  logic [DRN_W-1:0] drain_q;
  logic             err_q;
  logic             start_acc;
  logic             feed;
  logic             get_ok;
  logic             get_bad;
  logic             act_last;
  logic             row_last;
  logic             blk_last;

  assign start_acc     = TOPPEB_Start && (state_q == ST_IDLE);
  assign feed          = (state_q == ST_FEED);
  assign PEBPEC_RdyAct = feed && ACTPEB_Vld;
  assign get_ok        = PECPEB_GetAct && PEBPEC_RdyAct;
  assign get_bad       = PECPEB_GetAct && !PEBPEC_RdyAct;
  assign PEBACT_Pop    = get_ok;

  assign PEBPEC_StaRow = (state_q == ST_STAROW);
  assign PEBPEC_FnhRow = (state_q == ST_FNHROW);
  assign PEBPEC_FnhBlk = (state_q == ST_FNHBLK);
  assign PEBPEC_FnhFrm = (state_q == ST_FNHFRM);
  assign PEBTOP_Busy   = (state_q != ST_IDLE);
  assign PEBTOP_Err    = err_q;

  pec_row_sched_cnt #(.W(ACT_CNT_W)) u_act_cnt (
    .clk(clk), .rst_n(rst_n), .load_i(start_acc), .num_i(TOPPEB_NumAct),
    .clr_i(state_q == ST_STAROW), .inc_i(get_ok), .last_o(act_last)
  );

  pec_row_sched_cnt #(.W(ROW_CNT_W)) u_row_cnt (
    .clk(clk), .rst_n(rst_n), .load_i(start_acc), .num_i(TOPPEB_NumRow),
    .clr_i(1'b0), .inc_i(state_q == ST_FNHROW), .last_o(row_last)
  );

  pec_row_sched_cnt #(.W(BLK_CNT_W)) u_blk_cnt (
    .clk(clk), .rst_n(rst_n), .load_i(start_acc), .num_i(TOPPEB_NumBlk),
    .clr_i(1'b0), .inc_i(state_q == ST_FNHBLK), .last_o(blk_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (start_acc ? 1'b0 : err_q) | get_bad;
      case (state_q)
        ST_IDLE:   if (start_acc) state_q <= ST_STAROW;
        ST_STAROW: state_q <= ST_FEED;
        ST_FEED: begin
          if (get_ok && act_last) begin
            state_q <= ST_DRAIN;
            drain_q <= DRN_W'(DRAIN_CYC - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_q <= ST_FNHROW;
          else               drain_q <= drain_q - DRN_W'(1);
        end
        ST_FNHROW: state_q <= row_last ? ST_FNHBLK : ST_STAROW;
        ST_FNHBLK: state_q <= blk_last ? ST_FNHFRM : ST_STAROW;
        ST_FNHFRM: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PEC_ROW_SCHED_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] frm_q;

  // The accept cycle itself counts toward FrmCyc, hence the load value of 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      frm_q   <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
      frm_q   <= 32'd1;
    end else begin
      if (feed && !ACTPEB_Vld && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if ((state_q != ST_IDLE) && (frm_q != '1)) frm_q <= frm_q + 32'd1;
    end
  end

  assign PEBTOP_StallCyc = stall_q;
  assign PEBTOP_FrmCyc   = frm_q;
`endif

endmodule

// File: tb/tb_pec_row_sched.sv
// Scoreboard bench for pec_row_sched: frame model pushes expected pulse/pop order, monitor pops and compares.
`timescale 1ns/1ps
module tb_pec_row_sched;

  localparam int DRAIN_CYC = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_act = '0;
  logic [5:0] num_row = '0;
  logic [7:0] num_blk = '0;
  logic       vld = 1'b0;
  logic       get = 1'b0;
  logic       pop, rdy, sta, frow, fblk, ffrm, busy, err;
`ifdef PEC_ROW_SCHED_PERF_EN
  logic [31:0] stall_cyc, frm_cyc;
`endif

  pec_row_sched #(.ACT_CNT_W(8), .ROW_CNT_W(6), .BLK_CNT_W(8), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .TOPPEB_Start(start),
    .TOPPEB_NumAct(num_act), .TOPPEB_NumRow(num_row), .TOPPEB_NumBlk(num_blk),
    .ACTPEB_Vld(vld), .PEBACT_Pop(pop), .PEBPEC_RdyAct(rdy), .PECPEB_GetAct(get),
    .PEBPEC_StaRow(sta), .PEBPEC_FnhRow(frow), .PEBPEC_FnhBlk(fblk), .PEBPEC_FnhFrm(ffrm),
    .PEBTOP_Busy(busy), .PEBTOP_Err(err)
`ifdef PEC_ROW_SCHED_PERF_EN
    , .PEBTOP_StallCyc(stall_cyc), .PEBTOP_FrmCyc(frm_cyc)
`endif
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  byte exp_q[$];

  bit  vld_rand = 0, get_rand = 0, inject_illegal = 0, err_exp = 0, stall_active = 0;
  int  stall_left = 0;
  int  cyc = 0, last_pop = 0, last_r = 0, last_b = 0, pops_in_row = 0, rows_done = 0;
  bit  busy_chk_pending = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: expected event order of a whole frame, zero counts treated as one.
  task automatic push_frame(input int na, input int nr, input int nb);
    int a, r, b;
    a = (na == 0) ? 1 : na;
    r = (nr == 0) ? 1 : nr;
    b = (nb == 0) ? 1 : nb;
    for (int ib = 0; ib < b; ib++) begin
      for (int ir = 0; ir < r; ir++) begin
        exp_q.push_back("S");
        for (int ia = 0; ia < a; ia++) exp_q.push_back("P");
        exp_q.push_back("R");
      end
      exp_q.push_back("B");
    end
    exp_q.push_back("F");
  endtask

  task automatic ev(input byte code);
    byte e;
    if (exp_q.size() == 0) chk("unexpected_event", code, 0);
    else begin
      e = exp_q.pop_front();
      chk("event_order", code, e);
    end
  endtask

  // Monitor: samples mid-cycle, compares against the scoreboard queue.
  always begin
    int nev;
    @(negedge clk);
    #3;
    cyc++;
    if (rst_n) begin
      if (busy_chk_pending) begin
        chk("busy_after_frm", busy, 0);
        busy_chk_pending = 0;
      end
      nev = int'(sta) + int'(frow) + int'(fblk) + int'(ffrm) + int'(pop);
      if (nev != 0) chk("pulse_exclusive", nev, 1);
      if (pop) begin ev("P"); last_pop = cyc; pops_in_row++; end
      if (sta) begin ev("S"); pops_in_row = 0; end
      if (frow) begin
        ev("R");
        chk("drain_latency", cyc - last_pop, DRAIN_CYC + 1);
        last_r = cyc;
        rows_done++;
      end
      if (fblk) begin ev("B"); chk("blk_after_row", cyc - last_r, 1); last_b = cyc; end
      if (ffrm) begin ev("F"); chk("frm_after_blk", cyc - last_b, 1); busy_chk_pending = 1; end
      if (stall_active) chk("rdy_low_starved", rdy, 0);
    end
  end

  // Buffer and PEC[0] behaviour.
  always begin
    @(negedge clk);
    if (stall_left > 0) begin
      vld = 1'b0;
      stall_left--;
      stall_active = 1;
    end else begin
      stall_active = 0;
      vld = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    if (!rst_n) get = 1'b0;
    else if (inject_illegal && busy && !rdy) begin
      get = 1'b1;
      inject_illegal = 0;
      err_exp = 1;
    end else get = rdy && (get_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
  end

  task automatic wait_idle(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    chk("frame_done", busy, 0);
  endtask

  task automatic issue_start(input int na, input int nr, input int nb);
    @(negedge clk);
    num_act = 8'(na);
    num_row = 6'(nr);
    num_blk = 8'(nb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_act = 8'($urandom);
    num_row = 6'($urandom);
    num_blk = 8'($urandom);
  endtask

  task automatic run_frame(input int na, input int nr, input int nb,
                           input bit poke_busy, input bit starve, input bit illegal);
    push_frame(na, nr, nb);
    err_exp = 0;
    issue_start(na, nr, nb);
    inject_illegal = illegal;
    if (starve) begin
      for (int n = 0; n < 2000 && pops_in_row != 2; n++) @(posedge clk);
      chk("starve_reached", pops_in_row, 2);
      stall_left = 5;
    end
    if (poke_busy) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      num_act = 8'd1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(20000);
    inject_illegal = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("err_flag", err, err_exp);
`ifdef PEC_ROW_SCHED_PERF_EN
    if (starve) chk("stall_cyc", stall_cyc, 5);
`endif
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_pulses", {sta, frow, fblk, ffrm, pop}, 0);
    chk("rst_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(4, 2, 2, 0, 0, 0);
    run_frame(4, 1, 1, 0, 1, 0);
    run_frame(3, 1, 2, 0, 0, 1);
    run_frame(0, 0, 0, 0, 0, 0);
    run_frame(5, 2, 1, 1, 0, 0);

    // Abort during the second row's FEED; queued expectations are discarded.
    push_frame(3, 3, 1);
    rows_done = 0;
    issue_start(3, 3, 1);
    for (int n = 0; n < 2000 && !(rows_done >= 1 && pops_in_row >= 1); n++) @(posedge clk);
    chk("abort_reached", rows_done, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rdy", rdy, 0);
    chk("abort_outputs", {sta, frow, fblk, ffrm, pop, err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", busy, 0);
    run_frame(2, 2, 1, 0, 0, 0);

    vld_rand = 1;
    get_rand = 1;
    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0,
                $urandom_range(0, 1) == 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
